// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM encoding, oversampling
// constants and the baud divider calculation.
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;
  localparam int unsigned DATA_BITS  = 8;

  // Clocks per oversample tick, truncated toward zero.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO. The occupancy count is the sole full/empty authority;
// a pop frees its slot in the same cycle, so push+pop on a full FIFO succeeds.
module uart_byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign valid_o   = (count_q != {CW{1'b0}});
  assign full_o    = (count_q == CW'(DEPTH));
  assign data_o    = mem_q[rptr_q];
  assign count_o   = count_q;
  assign do_pop_s  = pop_i && valid_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push_s) begin
      wptr_d = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wptr_q] <= push_data_i;
    end else begin
      mem_q[wptr_q] <= mem_q[wptr_q];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver at 16x oversampling feeding a show-ahead byte FIFO with
// sticky overrun / framing-error flags.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  input  logic                          err_clr
);

  localparam int unsigned DIV   = baud_div(SYS_CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0]  MID_LAST = 4'(MID_SAMPLE - 1);
  localparam logic [3:0]  BIT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  logic             sync1_q;
  logic             rxs_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_s;
  logic [3:0]       scnt_q, scnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic             stop_ok_s;
  logic             stop_bad_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             ovr_set_s;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  // Held at zero in IDLE so tick phase is aligned to the start edge.
  assign tick_s = (state_q != ST_IDLE) && (div_q == CNT_W'(DIV - 1));

  // Oversample divider next-state.
  always_comb begin
    div_d = div_q;
    if (state_q == ST_IDLE) begin
      div_d = '0;
    end else if (tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + CNT_W'(1);
    end
  end

  // Receive FSM: next state, sample counter, shift register and stop verdict.
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    stop_ok_s  = 1'b0;
    stop_bad_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        scnt_d = 4'd0;
        bit_d  = 3'd0;
        if (!rxs_q) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && (scnt_q == MID_LAST)) begin
          scnt_d  = 4'd0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end else if (tick_s) begin
          scnt_d = scnt_q + 4'd1;
        end else begin
          scnt_d = scnt_q;
        end
      end
      ST_DATA: begin
        if (tick_s && (scnt_q == BIT_LAST)) begin
          scnt_d  = 4'd0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == LAST_BIT) ? ST_STOP : ST_DATA;
        end else if (tick_s) begin
          scnt_d = scnt_q + 4'd1;
        end else begin
          scnt_d = scnt_q;
        end
      end
      ST_STOP: begin
        if (tick_s && (scnt_q == BIT_LAST)) begin
          scnt_d     = 4'd0;
          stop_ok_s  = rxs_q;
          stop_bad_s = !rxs_q;
          state_d    = ST_WAIT_IDLE;
        end else if (tick_s) begin
          scnt_d = scnt_q + 4'd1;
        end else begin
          scnt_d = scnt_q;
        end
      end
      ST_WAIT_IDLE: begin
        if (rxs_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, divider and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      scnt_q  <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      scnt_q  <= scnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // A same-cycle pop makes room for the incoming byte.
  assign pop_s     = rd_valid && rd_ready;
  assign push_s    = stop_ok_s && (!full_s || pop_s);
  assign ovr_set_s = stop_ok_s && full_s && !pop_s;

  // Sticky flags; a new error wins over a coincident clear.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (err_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (stop_bad_s) begin
      frame_err_d = 1'b1;
    end else if (err_clr) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // Flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

  uart_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .push_data_i (shift_q),
    .full_o      (full_s),
    .pop_i       (pop_s),
    .valid_o     (rd_valid),
    .data_o      (rd_data),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_fifo;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       rx       = 1'b1;
  logic       rd_ready = 1'b0;
  logic       err_clr  = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       overrun;
  logic       frame_err;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] b77;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .SYS_CLK_FREQ (1_600_000),
    .BAUD_RATE    (100_000),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .err_clr    (err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    clk_n(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      clk_n(16);
    end
    rx = stop_bit;
    clk_n(16);
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    clk_n(n);
    rd_ready = 1'b0;
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got 0x%02h, nothing expected", rd_data);
      end else begin
        check("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    rst_n = 1'b0;
    clk_n(3);
    check("rst_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_data", {24'h0, rd_data}, 32'h0);
    check("rst_count", {29'h0, fifo_count}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    rst_n = 1'b1;
    clk_n(3);

    // 1: single good frame held in the FIFO, then popped
    send_frame(8'h55, 1'b1);
    clk_n(2);
    check("t1_valid", {31'h0, rd_valid}, 32'h1);
    check("t1_data", {24'h0, rd_data}, 32'h55);
    check("t1_count", {29'h0, fifo_count}, 32'h1);
    check("t1_overrun", {31'h0, overrun}, 32'h0);
    check("t1_frame_err", {31'h0, frame_err}, 32'h0);
    exp_q.push_back(8'h55);
    drain(1);
    check("t1_count_after_pop", {29'h0, fifo_count}, 32'h0);
    check("t1_valid_after_pop", {31'h0, rd_valid}, 32'h0);

    // 2: short low glitch is rejected, next frame is fine
    rx = 1'b0;
    clk_n(4);
    rx = 1'b1;
    clk_n(30);
    check("t2_glitch_count", {29'h0, fifo_count}, 32'h0);
    check("t2_glitch_frame_err", {31'h0, frame_err}, 32'h0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    clk_n(2);
    check("t2_count", {29'h0, fifo_count}, 32'h1);
    drain(1);

    // 3: bad stop bit, long low line, recovery and flag clear
    send_frame(8'hA3, 1'b0);
    clk_n(40);
    rx = 1'b1;
    clk_n(20);
    check("t3_frame_err", {31'h0, frame_err}, 32'h1);
    check("t3_count", {29'h0, fifo_count}, 32'h0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    clk_n(2);
    check("t3_count_good", {29'h0, fifo_count}, 32'h1);
    check("t3_frame_err_sticky", {31'h0, frame_err}, 32'h1);
    drain(1);
    err_clr = 1'b1;
    clk_n(1);
    err_clr = 1'b0;
    check("t3_frame_err_cleared", {31'h0, frame_err}, 32'h0);

    // 4: overflow, then clear coinciding with a fresh overrun
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    clk_n(2);
    check("t4_count_full", {29'h0, fifo_count}, 32'h4);
    check("t4_overrun", {31'h0, overrun}, 32'h1);
    fork
      send_frame(8'h06, 1'b1);
      begin
        clk_n(149);
        err_clr = 1'b1;
        clk_n(6);
        err_clr = 1'b0;
      end
    join
    clk_n(2);
    check("t4_overrun_set_wins", {31'h0, overrun}, 32'h1);
    check("t4_count_still_full", {29'h0, fifo_count}, 32'h4);
    drain(4);
    check("t4_count_drained", {29'h0, fifo_count}, 32'h0);
    err_clr = 1'b1;
    clk_n(1);
    err_clr = 1'b0;
    check("t4_overrun_cleared", {31'h0, overrun}, 32'h0);

    // 5: push into a full FIFO with a pop on the same cycle
    for (int b = 8'h61; b <= 8'h64; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    exp_q.push_back(8'h66);
    fork
      send_frame(8'h66, 1'b1);
      begin
        clk_n(154);
        rd_ready = 1'b1;
        clk_n(1);
        rd_ready = 1'b0;
      end
    join
    clk_n(2);
    check("t5_count", {29'h0, fifo_count}, 32'h4);
    check("t5_overrun", {31'h0, overrun}, 32'h0);
    drain(4);
    check("t5_count_drained", {29'h0, fifo_count}, 32'h0);
    check("t5_valid_drained", {31'h0, rd_valid}, 32'h0);

    // 6: reset in the middle of a frame with state to clear
    send_frame(8'h42, 1'b1);
    send_frame(8'h5A, 1'b0);
    rx = 1'b1;
    clk_n(20);
    check("t6_pre_count", {29'h0, fifo_count}, 32'h1);
    check("t6_pre_frame_err", {31'h0, frame_err}, 32'h1);
    b77 = 8'h77;
    rx = 1'b0;
    clk_n(16);
    for (int i = 0; i < 4; i++) begin
      rx = b77[i];
      clk_n(16);
    end
    rx = b77[4];
    clk_n(5);
    rst_n = 1'b0;
    clk_n(3);
    check("t6_rst_valid", {31'h0, rd_valid}, 32'h0);
    check("t6_rst_data", {24'h0, rd_data}, 32'h0);
    check("t6_rst_count", {29'h0, fifo_count}, 32'h0);
    check("t6_rst_overrun", {31'h0, overrun}, 32'h0);
    check("t6_rst_frame_err", {31'h0, frame_err}, 32'h0);
    rx = 1'b1;
    rst_n = 1'b1;
    clk_n(20);
    exp_q.push_back(8'h9A);
    send_frame(8'h9A, 1'b1);
    clk_n(2);
    check("t6_data", {24'h0, rd_data}, 32'h9A);
    check("t6_count", {29'h0, fifo_count}, 32'h1);
    drain(1);
    clk_n(2);

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
